// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Contents: register word indices, STATUS bit positions, funct3 access
// encodings, TX FSM state type and a load-size mask helper.
package mmio_uart_pkg;

    // Register word index within the 16-byte window (addr[3:2])
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_RSVD    = 2'd3;

    // STATUS bit positions
    localparam int unsigned ST_FULL      = 0;
    localparam int unsigned ST_EMPTY     = 1;
    localparam int unsigned ST_BUSY      = 2;
    localparam int unsigned ST_OVF       = 3;
    localparam int unsigned ST_COUNT_LSB = 8;

    // funct3 access sizes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

    // Mask applied to load data for the access width
    function automatic logic [31:0] size_mask(input logic [2:0] f3);
        case (f3)
            F3_SB, F3_LBU: size_mask = 32'h0000_00FF;
            F3_SH, F3_LHU: size_mask = 32'h0000_FFFF;
            F3_SW:         size_mask = 32'hFFFF_FFFF;
            default:       size_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// First-word-fall-through synchronous FIFO.
// Ports: clk, reset (async, active high), push/din write side,
// pop/dout read side, full/empty flags, count of stored entries.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);

    // Pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 console transmitter.
// Ports: clk, reset (async, active high); mem_write/addr/wdata/funct3 from
// the CPU store/load path; rdata registered load data (1-cycle latency);
// tx serial line (idle high); tx_busy frame in flight or FIFO non-empty.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        tx_busy
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic            hit;
    logic [1:0]      wsel;
    logic            wr_txdata;
    logic            wr_status;
    logic            wr_baud;
    logic [7:0]      fifo_dout;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic            pop;
    logic            overflow;
    logic [15:0]     baud_div;
    logic [31:0]     status;
    logic [31:0]     reg_word;
    logic            unused_bits;

    tx_state_e   state, state_n;
    logic [15:0] timer, timer_n;
    logic [15:0] div_l, div_n;
    logic [2:0]  bit_idx, bit_n;
    logic [7:0]  shift, shift_n;
    logic        tx_n;
    logic        tx_busy_n;

    assign unused_bits = ^{wdata[31:16]};

    // Address decode
    assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
    assign wsel      = addr[3:2];
    assign wr_txdata = mem_write & hit & (wsel == REG_TXDATA);
    assign wr_status = mem_write & hit & (wsel == REG_STATUS);
    assign wr_baud   = mem_write & hit & (wsel == REG_BAUDDIV);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_txdata),
        .din   (wdata[7:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sticky overflow: a dropped push sets it, W1C clears it, set wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (wr_txdata & fifo_full & ~pop) begin
            overflow <= 1'b1;
        end else if (wr_status & wdata[ST_OVF]) begin
            overflow <= 1'b0;
        end
    end

    // Baud divider register; byte stores touch only the low byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_div <= DEFAULT_DIV;
        end else if (wr_baud) begin
            if (funct3[1:0] == F3_SB[1:0]) baud_div[7:0] <= wdata[7:0];
            else                           baud_div     <= wdata[15:0];
        end
    end

    // Read mux
    always_comb begin
        status                      = '0;
        status[ST_FULL]             = fifo_full;
        status[ST_EMPTY]            = fifo_empty;
        status[ST_BUSY]             = tx_busy;
        status[ST_OVF]              = overflow;
        status[ST_COUNT_LSB +: 8]   = 8'(fifo_count);
        reg_word = '0;
        if (hit) begin
            case (wsel)
                REG_STATUS:  reg_word = status;
                REG_BAUDDIV: reg_word = {16'h0000, baud_div};
                REG_RSVD:    reg_word = '0;
                default:     reg_word = '0;
            endcase
        end
    end

    // Sub-word loads take the addressed lane, then mask to access width
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rdata <= '0;
        else       rdata <= (reg_word >> {addr[1:0], 3'b000}) & size_mask(funct3);
    end

    // TX FSM registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            timer   <= '0;
            div_l   <= DEFAULT_DIV;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            div_l   <= div_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
            tx      <= tx_n;
            tx_busy <= tx_busy_n;
        end
    end

    // TX FSM next state; tx_n is the line level for the coming cycle
    always_comb begin
        state_n   = state;
        timer_n   = timer;
        div_n     = div_l;
        bit_n     = bit_idx;
        shift_n   = shift;
        tx_n      = tx;
        pop       = 1'b0;
        tx_busy_n = (state != S_IDLE) | ~fifo_empty;
        case (state)
            S_IDLE: begin
                tx_n = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_dout;
                    div_n   = baud_div;
                    timer_n = baud_div;
                    tx_n    = 1'b0;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (timer == '0) begin
                    state_n = S_DATA;
                    bit_n   = '0;
                    timer_n = div_l;
                    tx_n    = shift[0];
                end else begin
                    timer_n = timer - 16'd1;
                end
            end
            S_DATA: begin
                if (timer == '0) begin
                    timer_n = div_l;
                    if (bit_idx == 3'd7) begin
                        state_n = S_STOP;
                        tx_n    = 1'b1;
                    end else begin
                        shift_n = {1'b0, shift[7:1]};
                        bit_n   = bit_idx + 3'd1;
                        tx_n    = shift[1];
                    end
                end else begin
                    timer_n = timer - 16'd1;
                end
            end
            S_STOP: begin
                if (timer == '0) begin
                    // Back-to-back: pop the next byte without an idle cycle
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_n = fifo_dout;
                        div_n   = baud_div;
                        timer_n = baud_div;
                        tx_n    = 1'b0;
                        state_n = S_START;
                    end else begin
                        tx_n    = 1'b1;
                        state_n = S_IDLE;
                    end
                end else begin
                    timer_n = timer - 16'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: directed CPU stores/loads, with a
// serial-line monitor that decodes every frame against a byte scoreboard.
module tb_mmio_uart_tx;

    localparam logic [31:0] TXD  = 32'h1000_0000;
    localparam logic [31:0] STA  = 32'h1000_0004;
    localparam logic [31:0] BAUD = 32'h1000_0008;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic [31:0] rdata;
    logic        tx;
    logic        tx_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Monitor / scoreboard state
    logic [7:0] sb[$];
    int mon_div   = 867;
    int frames    = 0;
    int starts    = 0;
    int b2b       = 0;
    int last_end  = -10;
    int mon_start = 0;

    mmio_uart_tx dut (
        .clk       (clk),
        .reset     (reset),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .funct3    (funct3),
        .rdata     (rdata),
        .tx        (tx),
        .tx_busy   (tx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        mem_write = 1'b1;
        addr      = a;
        wdata     = d;
        funct3    = f;
        @(negedge clk);
        mem_write = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] f, output logic [31:0] d);
        mem_write = 1'b0;
        addr      = a;
        funct3    = f;
        @(negedge clk);
        d = rdata;
    endtask

    task automatic send(input logic [7:0] b);
        sb.push_back(b);
        store(TXD, {24'h0, b}, 3'b000);
    endtask

    task automatic wait_frames(input int n, input int lim);
        int k = 0;
        while (frames < n && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("frames_done", 32'(frames), 32'(n));
        repeat (3) @(negedge clk);
    endtask

    // Serial monitor: checks every cycle of each frame against the expected byte
    initial begin : monitor
        int p, lim, errs, bi;
        logic [7:0] exp_b, got_b;
        logic has, abort_f, e;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && tx === 1'b0) begin
                starts++;
                mon_start = cyc;
                if (cyc == last_end + 1) b2b++;
                p       = mon_div + 1;
                lim     = 10 * p;
                has     = (sb.size() > 0);
                exp_b   = has ? sb.pop_front() : 8'h00;
                got_b   = 8'h00;
                errs    = 0;
                abort_f = 1'b0;
                for (int k = 0; k < lim && !abort_f; k++) begin
                    if (k > 0) @(negedge clk);
                    if (reset !== 1'b0) begin
                        abort_f = 1'b1;
                    end else begin
                        bi = k / p;
                        e  = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : exp_b[bi-1];
                        if (tx !== e) errs++;
                        if ((k % p) == (p / 2) && bi >= 1 && bi <= 8) got_b[bi-1] = tx;
                    end
                end
                if (!abort_f) begin
                    chk("sb_entry", 32'(has), 32'd1);
                    chk("frame_byte", 32'(got_b), 32'(exp_b));
                    chk("frame_shape_errs", 32'(errs), 32'd0);
                    frames++;
                    last_end = cyc;
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] d;
        int f0, b0, s0;
        reset     = 1'b1;
        mem_write = 1'b0;
        addr      = '0;
        wdata     = '0;
        funct3    = 3'b010;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        reset = 1'b0;

        // T1: reset register values and decode
        load(STA, 3'b010, d);             chk("t1_status", d, 32'h0000_0002);
        chk("t1_tx", 32'(tx), 32'd1);
        load(BAUD, 3'b010, d);            chk("t1_bauddiv", d, 32'd867);
        load(32'h1000_0009, 3'b100, d);   chk("t1_lbu_lane1", d, 32'h0000_0003);
        load(32'h2000_0004, 3'b010, d);   chk("t1_nonhit", d, 32'h0);
        load(TXD, 3'b010, d);             chk("t1_txdata_rd", d, 32'h0);
        store(BAUD, 32'hABCD_1234, 3'b010);
        load(BAUD, 3'b010, d);            chk("t1_baud_sw", d, 32'h0000_1234);
        store(BAUD, 32'h0000_00FF, 3'b000);
        load(BAUD, 3'b010, d);            chk("t1_baud_sb", d, 32'h0000_12FF);
        load(32'h1000_000A, 3'b101, d);   chk("t1_lhu_upper", d, 32'h0);
        store(32'h1000_000C, 32'hFFFF_FFFF, 3'b010);
        load(32'h1000_000C, 3'b010, d);   chk("t1_rsvd", d, 32'h0);

        // T2: single 0x55 frame at DIV=3
        store(BAUD, 32'h0000_0003, 3'b001);
        mon_div = 3;
        f0 = frames;
        send(8'h55);
        wait_frames(f0 + 1, 200);
        chk("t2_busy_low", 32'(tx_busy), 32'd0);
        chk("t2_tx_idle", 32'(tx), 32'd1);

        // T3: 17 rapid bytes accepted, 18th dropped, back-to-back frames
        f0 = frames;
        b0 = b2b;
        for (int i = 0; i < 17; i++) send(8'(i));
        store(TXD, 32'h0000_0011, 3'b000);
        load(STA, 3'b010, d);             chk("t3_status_ovf", d, 32'h0000_100D);
        wait_frames(f0 + 17, 17 * 40 + 200);
        chk("t3_b2b", 32'(b2b - b0), 32'd16);
        store(STA, 32'h0000_0008, 3'b010);
        load(STA, 3'b010, d);             chk("t3_status_clr", d, 32'h0000_0002);

        // T4: push on the exact pop cycle with the FIFO full
        f0 = frames;
        send(8'hA0);
        for (int i = 0; i < 16; i++) send(8'(8'hB0 + 8'(i)));
        s0 = 0;
        while (cyc != mon_start + 39 && s0 < 200) begin
            @(negedge clk);
            s0++;
        end
        send(8'hEE);
        load(STA, 3'b010, d);             chk("t4_status_full", d, 32'h0000_1005);
        wait_frames(f0 + 18, 18 * 40 + 200);

        // T5: BAUDDIV change mid-frame applies to the next frame only
        f0 = frames;
        send(8'h3C);
        send(8'hC3);
        repeat (10) @(negedge clk);
        store(BAUD, 32'h0000_0001, 3'b001);
        mon_div = 1;
        wait_frames(f0 + 2, 200);
        load(BAUD, 3'b010, d);            chk("t5_baud", d, 32'h0000_0001);

        // T7: DIV=0, one clock per bit, back-to-back
        store(BAUD, 32'h0000_0000, 3'b000);
        mon_div = 0;
        f0 = frames;
        b0 = b2b;
        send(8'hA3);
        send(8'h5A);
        wait_frames(f0 + 2, 100);
        chk("t7_b2b", 32'(b2b - b0), 32'd1);

        // T6: reset mid-DATA flushes everything
        store(BAUD, 32'h0000_0003, 3'b001);
        mon_div = 3;
        send(8'h81);
        send(8'h7E);
        repeat (15) @(negedge clk);
        chk("t6_tx_data_bit", 32'(tx), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_tx", 32'(tx), 32'd1);
        chk("t6_async_busy", 32'(tx_busy), 32'd0);
        sb.delete();
        f0 = frames;
        s0 = starts;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        load(STA, 3'b010, d);             chk("t6_status", d, 32'h0000_0002);
        repeat (100) @(negedge clk);
        chk("t6_no_frame_starts", 32'(starts), 32'(s0));
        chk("t6_no_frames", 32'(frames), 32'(f0));
        chk("t6_tx_idle", 32'(tx), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
